// File: rtl/ps2_key_fifo_if.sv
// Wishbone bus interface used by the I/O sub-bus peripherals.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        stall;

    modport slave  (input cyc, stb, we, adr, sel, dat_i, output dat_o, ack, stall);
    modport master (output cyc, stb, we, adr, sel, dat_i, input dat_o, ack, stall);
endinterface

// File: rtl/ps2_key_fifo.sv
// PS/2 key event FIFO: captures toggle-encoded hps_io key words and exposes
// them to the CPU as DATA/STATUS/CTRL registers with a level interrupt.
module ps2_key_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    if_wb.slave         bus,
    input  logic [10:0] ps2_key,
    output logic        interrupt
);

    logic [9:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow, ien, primed, prev_toggle;
    logic          empty, full;
    logic          accept, rd_data, wr_status, wr_ctrl, rd_any;
    logic          push_req, push, pop, flush, ovf_set, ovf_clr;
    logic [31:0]   rdata;
    logic [9:0]    head;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    assign accept    = bus.cyc & bus.stb;
    assign rd_any    = accept & ~bus.we;
    assign rd_data   = rd_any & (bus.adr[3:2] == 2'd0);
    assign wr_status = accept & bus.we & (bus.adr[3:2] == 2'd1);
    assign wr_ctrl   = accept & bus.we & (bus.adr[3:2] == 2'd2);

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign flush    = wr_ctrl & bus.dat_i[1];
    assign pop      = rd_data & ~empty & ~flush;
    assign push_req = primed & (ps2_key[10] != prev_toggle);
    assign push     = push_req & ~flush & (~full | pop);
    assign ovf_set  = push_req & ~flush & full & ~pop;
    assign ovf_clr  = wr_status & bus.dat_i[18];

    assign interrupt = ien & ~empty;
    assign bus.stall = 1'b0;

    always_comb begin
        rdata = '0;
        if (rd_any) begin
            case (bus.adr[3:2])
                2'd0: if (!empty) rdata = {1'b1, 21'b0, head};
                2'd1: begin
                    rdata[AW:0] = count;
                    rdata[16]   = empty;
                    rdata[17]   = full;
                    rdata[18]   = overflow;
                end
                2'd2: rdata[0] = ien;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= ps2_key[9:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            ien         <= 1'b0;
            primed      <= 1'b0;
            prev_toggle <= 1'b0;
            bus.ack     <= 1'b0;
            bus.dat_o   <= '0;
        end else begin
            // First edge after reset only samples the toggle so a stale level is not an event.
            primed <= 1'b1;
            if (!primed || push_req) prev_toggle <= ps2_key[10];

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end

            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            if (wr_ctrl) ien <= bus.dat_i[0];

            bus.ack <= accept;
            if (accept) bus.dat_o <= rdata;
        end
    end

    logic unused;
    assign unused = ^{bus.adr[31:4], bus.adr[1:0], bus.sel, bus.dat_i[31:19], bus.dat_i[17:2]};

endmodule
